// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the run/halt sequencer: state encoding, default
// parameter values and the syscall halt decode.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } run_state_t;

    localparam int          CNT_W_DEFAULT     = 32;
    localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;

    function automatic logic is_halt_code(input logic [31:0] v0, input logic [31:0] code);
        return (v0 == code);
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// Board/decoder/datapath bundle seen by the run controller. The master side
// drives Go/Step and decoder fields; the slave side is the controller.
interface run_controller_if
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic              Go;
    logic              Step;
    logic              SysCALL;
    logic              JMP;
    logic              JAL;
    logic              JR;
    logic              Beq;
    logic              Bne;
    logic              BLTZ;
    logic              BranchTaken;
    logic [31:0]       V0;
    logic [31:0]       A0;
    logic              PcEn;
    logic              Halted;
    logic              DispEn;
    logic [31:0]       DispData;
    logic [CNT_W-1:0]  CycleCnt;
    logic [CNT_W-1:0]  UncondCnt;
    logic [CNT_W-1:0]  CondTakenCnt;

    modport master (
        output Go, Step, SysCALL, JMP, JAL, JR, Beq, Bne, BLTZ, BranchTaken, V0, A0,
        input  PcEn, Halted, DispEn, DispData, CycleCnt, UncondCnt, CondTakenCnt
    );

    modport slave (
        input  Go, Step, SysCALL, JMP, JAL, JR, Beq, Bne, BLTZ, BranchTaken, V0, A0,
        output PcEn, Halted, DispEn, DispData, CycleCnt, UncondCnt, CondTakenCnt
    );
endinterface

// File: rtl/run_controller_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count state: increments on inc until saturated
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/halt sequencer: gates PC advance, handles SysCALL halt/display and
// feeds the saturating statistics counters.
module run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int          CNT_W     = CNT_W_DEFAULT,
    parameter logic [31:0] HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST_N,
    run_controller_if.slave bus
);

    run_state_t  state_r;
    run_state_t  state_next_s;
    logic        step_q_r;
    logic        step_armed_r;
    logic        step_rise_s;
    logic        exec_s;
    logic        halt_sc_s;
    logic        disp_sc_s;
    logic        pc_en_s;
    logic        uncond_inc_s;
    logic        cond_inc_s;
    logic        halted_r;
    logic        disp_en_r;
    logic [31:0] disp_data_r;

    // Step edge detect; the arm flag stays low through reset and until Step
    // has been seen low, so a Step held across reset release never fires.
    always_comb begin
        step_rise_s  = bus.Step & ~step_q_r & step_armed_r;
        exec_s       = ((state_r == RUN) & bus.Go) | ((state_r == IDLE) & step_rise_s);
        halt_sc_s    = exec_s & bus.SysCALL & is_halt_code(bus.V0, HALT_CODE);
        disp_sc_s    = exec_s & bus.SysCALL & ~halt_sc_s;
        pc_en_s      = exec_s & ~halt_sc_s;
        uncond_inc_s = exec_s & (bus.JMP | bus.JAL | bus.JR);
        cond_inc_s   = exec_s & ~halt_sc_s & (bus.Beq | bus.Bne | bus.BLTZ) & bus.BranchTaken;
    end

    // Next-state decode; HALT is only left through reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (halt_sc_s) begin
                    state_next_s = HALT;
                end else if (bus.Go) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (halt_sc_s) begin
                    state_next_s = HALT;
                end else if (!bus.Go) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, Step history and halt flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            step_q_r     <= 1'b0;
            step_armed_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            step_q_r     <= bus.Step;
            step_armed_r <= step_armed_r | ~bus.Step;
            halted_r     <= (state_next_s == HALT);
        end
    end

    // Display register: one-cycle strobe with $a0 latched on a non-halting syscall
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            disp_en_r   <= 1'b0;
            disp_data_r <= 32'd0;
        end else begin
            disp_en_r <= disp_sc_s;
            if (disp_sc_s) begin
                disp_data_r <= bus.A0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (exec_s),
        .q     (bus.CycleCnt)
    );

    sat_counter #(.W(CNT_W)) u_uncond_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (uncond_inc_s),
        .q     (bus.UncondCnt)
    );

    sat_counter #(.W(CNT_W)) u_cond_taken_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (cond_inc_s),
        .q     (bus.CondTakenCnt)
    );

    assign bus.PcEn     = pc_en_s;
    assign bus.Halted   = halted_r;
    assign bus.DispEn   = disp_en_r;
    assign bus.DispData = disp_data_r;

endmodule

// File: tb/tb_run_controller.sv
// Table-driven bench for run_controller with a scoreboard queue for the
// post-edge outputs, plus hand-written reset and saturation sequences.
module tb_run_controller;
    import cpu_ctrl_pkg::*;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    always #5 CLK = ~CLK;

    run_controller_if #(.CNT_W(32)) bus ();
    run_controller_if #(.CNT_W(4))  bus4 ();

    assign bus4.Go          = bus.Go;
    assign bus4.Step        = bus.Step;
    assign bus4.SysCALL     = bus.SysCALL;
    assign bus4.JMP         = bus.JMP;
    assign bus4.JAL         = bus.JAL;
    assign bus4.JR          = bus.JR;
    assign bus4.Beq         = bus.Beq;
    assign bus4.Bne         = bus.Bne;
    assign bus4.BLTZ        = bus.BLTZ;
    assign bus4.BranchTaken = bus.BranchTaken;
    assign bus4.V0          = bus.V0;
    assign bus4.A0          = bus.A0;

    run_controller #(.CNT_W(32), .HALT_CODE(32'd10)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    run_controller #(.CNT_W(4), .HALT_CODE(32'd10)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus4)
    );

    // decoder field order: {SysCALL, JMP, JAL, JR, Beq, Bne, BLTZ}
    localparam logic [6:0] D_NONE = 7'b0000000;
    localparam logic [6:0] D_SYS  = 7'b1000000;
    localparam logic [6:0] D_JMP  = 7'b0100000;
    localparam logic [6:0] D_JAL  = 7'b0010000;
    localparam logic [6:0] D_JR   = 7'b0001000;
    localparam logic [6:0] D_BEQ  = 7'b0000100;
    localparam logic [6:0] D_BNE  = 7'b0000010;
    localparam logic [6:0] D_BLTZ = 7'b0000001;

    typedef struct {
        string       name;
        logic        go;
        logic        step;
        logic [6:0]  dec;
        logic        taken;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        exp_pc;
        logic        exp_de;
        logic [31:0] exp_dd;
        logic        exp_halt;
        logic [31:0] exp_cyc;
        logic [31:0] exp_unc;
        logic [31:0] exp_cond;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string n, logic go, logic step, logic [6:0] dec, logic taken,
                                logic [31:0] v0, logic [31:0] a0, logic pc, logic de,
                                logic [31:0] dd, logic h, logic [31:0] c, logic [31:0] u,
                                logic [31:0] t);
        vec_t v;
        v.name = n; v.go = go; v.step = step; v.dec = dec; v.taken = taken;
        v.v0 = v0; v.a0 = a0; v.exp_pc = pc; v.exp_de = de; v.exp_dd = dd;
        v.exp_halt = h; v.exp_cyc = c; v.exp_unc = u; v.exp_cond = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Go          = v.go;
        bus.Step        = v.step;
        {bus.SysCALL, bus.JMP, bus.JAL, bus.JR, bus.Beq, bus.Bne, bus.BLTZ} = v.dec;
        bus.BranchTaken = v.taken;
        bus.V0          = v.v0;
        bus.A0          = v.a0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge CLK);
        drive(v);
        #1;
        check({v.name, "/PcEn"}, 32'(bus.PcEn), 32'(v.exp_pc));
        sb_q.push_back(v);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        check({e.name, "/DispEn"},       32'(bus.DispEn),  32'(e.exp_de));
        check({e.name, "/DispData"},     bus.DispData,     e.exp_dd);
        check({e.name, "/Halted"},       32'(bus.Halted),  32'(e.exp_halt));
        check({e.name, "/CycleCnt"},     bus.CycleCnt,     e.exp_cyc);
        check({e.name, "/UncondCnt"},    bus.UncondCnt,    e.exp_unc);
        check({e.name, "/CondTakenCnt"}, bus.CondTakenCnt, e.exp_cond);
    endtask

    initial begin
        // run from IDLE: one transition cycle, then five commits, then pause
        vecs.push_back(mk("a_go0",  1'b1, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0));
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(mk($sformatf("a_run%0d", i), 1'b1, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0,
                              1'b1, 1'b0, 32'd0, 1'b0, 32'(i), 32'd0, 32'd0));
        end
        vecs.push_back(mk("a_pause", 1'b0, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd5, 32'd0, 32'd0));
        // step mode: hold high 4 cycles, then two more pulses
        vecs.push_back(mk("b_s1",  1'b0, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd6, 32'd0, 32'd0));
        for (int i = 2; i <= 4; i++) begin
            vecs.push_back(mk($sformatf("b_s%0d", i), 1'b0, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0,
                              1'b0, 1'b0, 32'd0, 1'b0, 32'd6, 32'd0, 32'd0));
        end
        vecs.push_back(mk("b_l1", 1'b0, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd6, 32'd0, 32'd0));
        vecs.push_back(mk("b_h2", 1'b0, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd7, 32'd0, 32'd0));
        vecs.push_back(mk("b_l2", 1'b0, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7, 32'd0, 32'd0));
        vecs.push_back(mk("b_h3", 1'b0, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd8, 32'd0, 32'd0));
        vecs.push_back(mk("b_l3", 1'b0, 1'b0, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd8, 32'd0, 32'd0));
        // Go together with a Step edge in IDLE executes and enters RUN
        vecs.push_back(mk("b_both", 1'b1, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd9, 32'd0, 32'd0));
        // mixed branch/jump stream
        vecs.push_back(mk("c_jal",  1'b1, 1'b0, D_JAL,  1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd10, 32'd1, 32'd0));
        vecs.push_back(mk("c_jr",   1'b1, 1'b0, D_JR,   1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd11, 32'd2, 32'd0));
        vecs.push_back(mk("c_beq",  1'b1, 1'b0, D_BEQ,  1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd12, 32'd2, 32'd1));
        vecs.push_back(mk("c_bne",  1'b1, 1'b0, D_BNE,  1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd13, 32'd2, 32'd1));
        vecs.push_back(mk("c_bltz", 1'b1, 1'b0, D_BLTZ, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd14, 32'd2, 32'd2));
        // display syscall, follow-up, halting syscall, then ignored activity
        vecs.push_back(mk("d_disp", 1'b1, 1'b0, D_SYS,  1'b0, 32'd1, 32'h1234, 1'b1, 1'b1, 32'h1234, 1'b0, 32'd15, 32'd2, 32'd2));
        vecs.push_back(mk("d_next", 1'b1, 1'b0, D_NONE, 1'b0, 32'd1, 32'hdead, 1'b1, 1'b0, 32'h1234, 1'b0, 32'd16, 32'd2, 32'd2));
        vecs.push_back(mk("d_halt", 1'b1, 1'b0, D_SYS | D_BEQ, 1'b1, 32'd10, 32'h5555, 1'b0, 1'b0, 32'h1234, 1'b1, 32'd17, 32'd2, 32'd2));
        vecs.push_back(mk("d_jmp",  1'b1, 1'b0, D_JMP,  1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1234, 1'b1, 32'd17, 32'd2, 32'd2));
        vecs.push_back(mk("d_s0",   1'b0, 1'b0, D_BEQ,  1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1234, 1'b1, 32'd17, 32'd2, 32'd2));
        vecs.push_back(mk("d_s1",   1'b0, 1'b1, D_BEQ,  1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1234, 1'b1, 32'd17, 32'd2, 32'd2));
        vecs.push_back(mk("d_sys",  1'b0, 1'b0, D_SYS,  1'b0, 32'd1, 32'h7777, 1'b0, 1'b0, 32'h1234, 1'b1, 32'd17, 32'd2, 32'd2));

        // power-on reset with Step held high: PcEn must stay masked
        drive(mk("rst", 1'b0, 1'b1, D_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0));
        #1 RST_N = 1'b0;
        #1;
        check("rst/PcEn",         32'(bus.PcEn),    32'd0);
        check("rst/Halted",       32'(bus.Halted),  32'd0);
        check("rst/DispEn",       32'(bus.DispEn),  32'd0);
        check("rst/DispData",     bus.DispData,     32'd0);
        check("rst/CycleCnt",     bus.CycleCnt,     32'd0);
        check("rst/UncondCnt",    bus.UncondCnt,    32'd0);
        check("rst/CondTakenCnt", bus.CondTakenCnt, 32'd0);
        @(negedge CLK);
        bus.Step = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while halted, released with Step still high
        @(negedge CLK);
        bus.Go = 1'b1; bus.Step = 1'b1;
        {bus.SysCALL, bus.JMP, bus.JAL, bus.JR, bus.Beq, bus.Bne, bus.BLTZ} = D_NONE;
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst/Halted",   32'(bus.Halted), 32'd0);
        check("mid_rst/PcEn",     32'(bus.PcEn),   32'd0);
        check("mid_rst/DispData", bus.DispData,    32'd0);
        check("mid_rst/CycleCnt", bus.CycleCnt,    32'd0);
        check("mid_rst/UncondCnt", bus.UncondCnt,  32'd0);
        @(negedge CLK);
        bus.Go = 1'b0;
        RST_N  = 1'b1;
        #1;
        check("held_step/PcEn", 32'(bus.PcEn), 32'd0);
        @(posedge CLK); #1;
        check("held_step/CycleCnt", bus.CycleCnt, 32'd0);
        @(negedge CLK);
        bus.Step = 1'b0;
        @(negedge CLK);
        bus.Step = 1'b1;
        #1;
        check("rearm/PcEn", 32'(bus.PcEn), 32'd1);
        @(posedge CLK); #1;
        check("rearm/CycleCnt", bus.CycleCnt, 32'd1);

        // saturation: 4-bit counter copy must stick at 15
        @(negedge CLK);
        bus.Step = 1'b0; bus.Go = 1'b0;
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N  = 1'b1;
        bus.Go = 1'b1;
        repeat (21) @(posedge CLK);
        #1;
        check("sat/CycleCnt32", bus.CycleCnt,       32'd20);
        check("sat/CycleCnt4",  32'(bus4.CycleCnt), 32'd15);
        check("sat/PcEn4",      32'(bus4.PcEn),     32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("sat_rst/CycleCnt4",  32'(bus4.CycleCnt), 32'd0);
        check("sat_rst/CycleCnt32", bus.CycleCnt,       32'd0);
        check("sat_rst/Halted4",    32'(bus4.Halted),   32'd0);
        check("sat_rst/PcEn4",      32'(bus4.PcEn),     32'd0);
        RST_N = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
